tdm_deserializer: RTL and testbench

Receives a serial TDM frame of five 32-bit channel slots on a single data line and presents the five channel words in parallel. It sits between an external TDM serial link (data, frame sync and bit strobe) and the downstream parallel consumers. After each complete frame it updates all channel outputs together and pulses a ready flag.

---
 rtl/tdm_deserializer_pkg.sv | 30 +++
 rtl/tdm_deserializer_if.sv | 49 ++++
 rtl/tdm_bit_counter.sv | 64 ++++++
 rtl/tdm_deserializer.sv | 73 +++++++
 tb/tb_tdm_deserializer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/tdm_deserializer_pkg.sv
// tdm_deserializer_pkg
// Shared constants and types for the TDM deserializer slice.
//   CH_WIDTH    bits per channel slot
//   NUM_CH      channel slots per frame
//   FRAME_BITS  bits per complete frame (NUM_CH * CH_WIDTH)
//   CNT_WIDTH   width of the frame bit counter
//   state_t     receiver state {IDLE, RECEIVE}
package tdm_deserializer_pkg;

  localparam int CH_WIDTH   = 32;
  localparam int NUM_CH     = 5;
  localparam int FRAME_BITS = NUM_CH * CH_WIDTH;
  localparam int CNT_WIDTH  = 8;

  typedef logic [CNT_WIDTH-1:0] bit_cnt_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } state_t;

  // Counter value of the final bit of a frame.
  localparam bit_cnt_t LAST_BIT = bit_cnt_t'(FRAME_BITS - 1);

  // Next counter value; kept here so the increment width is defined once.
  function automatic bit_cnt_t next_count(input bit_cnt_t count);
    return count + bit_cnt_t'(1);
  endfunction

endpackage

// File: rtl/tdm_deserializer_if.sv
// tdm_deserializer_if
// Bundles the serial link inputs and the parallel channel outputs.
//   tdm_data    serial bit, valid when tdm_clk = 1
//   tdm_sync    frame-start marker, valid when tdm_clk = 1
//   tdm_clk     bit strobe (synchronous enable, not a clock)
//   word_ready  one-cycle pulse when ch0..ch4 hold a new frame
//   ch0..ch4    channel words of the last completed frame
// Modports:
//   master  the link/consumer side (drives the serial inputs)
//   slave   the deserializer itself
interface tdm_deserializer_if
  import tdm_deserializer_pkg::*;
  ();

  logic                tdm_data;
  logic                tdm_sync;
  logic                tdm_clk;
  logic                word_ready;
  logic [CH_WIDTH-1:0] ch0;
  logic [CH_WIDTH-1:0] ch1;
  logic [CH_WIDTH-1:0] ch2;
  logic [CH_WIDTH-1:0] ch3;
  logic [CH_WIDTH-1:0] ch4;

  modport master (
    output tdm_data,
    output tdm_sync,
    output tdm_clk,
    input  word_ready,
    input  ch0,
    input  ch1,
    input  ch2,
    input  ch3,
    input  ch4
  );

  modport slave (
    input  tdm_data,
    input  tdm_sync,
    input  tdm_clk,
    output word_ready,
    output ch0,
    output ch1,
    output ch2,
    output ch3,
    output ch4
  );

endinterface

// File: rtl/tdm_bit_counter.sv
// tdm_bit_counter
// Frame sequencing for the TDM deserializer: sync detection, bit counting
// and frame-complete generation.
//   clock       system clock (rising edge)
//   reset       asynchronous active-high reset
//   tdm_clk     bit strobe; only qualified cycles advance the counter
//   tdm_sync    frame-start marker
//   wr_en       the current bit must be written into the shift buffer
//   wr_index    frame bit position of the current bit
//   frame_done  registered one-cycle pulse after bit FRAME_BITS-1 is stored
//   state       current receiver state
module tdm_bit_counter
  import tdm_deserializer_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     tdm_clk,
  input  logic     tdm_sync,
  output logic     wr_en,
  output bit_cnt_t wr_index,
  output logic     frame_done,
  output state_t   state
);

  state_t   state_reg;
  bit_cnt_t count_reg;
  logic     frame_done_reg;

  // A sync always wins: it both starts a frame from IDLE and restarts a
  // partial frame, and in either case the current bit is frame bit 0.
  assign wr_en    = tdm_clk & (tdm_sync | (state_reg == RECEIVE));
  assign wr_index = tdm_sync ? '0 : count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (tdm_clk) begin
        if (tdm_sync) begin
          // Bit 0 is taken this cycle, so the next bit lands at 1.
          state_reg <= RECEIVE;
          count_reg <= bit_cnt_t'(1);
        end else if (state_reg == RECEIVE) begin
          if (count_reg == LAST_BIT) begin
            // Frame complete; the counter parks at 0 and a fresh sync is
            // needed before anything else is captured.
            state_reg      <= IDLE;
            count_reg      <= '0;
            frame_done_reg <= 1'b1;
          end else begin
            count_reg <= next_count(count_reg);
          end
        end
      end
    end
  end

  assign frame_done = frame_done_reg;
  assign state      = state_reg;

endmodule

// File: rtl/tdm_deserializer.sv
// tdm_deserializer
// Receives a TDM frame of NUM_CH slots of CH_WIDTH bits (each slot LSB
// first, ch0 first) and presents the channel words in parallel. The frame
// is assembled in a shift buffer and copied to the output registers as a
// whole, so ch0..ch4 stay stable while the next frame arrives.
//   clock  system clock (rising edge)
//   reset  asynchronous active-high reset
//   bus    tdm_deserializer_if.slave: tdm_data/tdm_sync/tdm_clk in,
//          word_ready and ch0..ch4 out
module tdm_deserializer
  import tdm_deserializer_pkg::*;
(
  input logic               clock,
  input logic               reset,
  tdm_deserializer_if.slave bus
);

  logic                             wr_en;
  bit_cnt_t                         wr_index;
  logic                             frame_done;
  state_t                           state;

  logic [FRAME_BITS-1:0]            shift_reg;
  logic [NUM_CH-1:0][CH_WIDTH-1:0]  ch_reg;
  logic                             word_ready_reg;

  tdm_bit_counter u_bit_counter (
    .clock      (clock),
    .reset      (reset),
    .tdm_clk    (bus.tdm_clk),
    .tdm_sync   (bus.tdm_sync),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .frame_done (frame_done),
    .state      (state)
  );

  // Bits are written at their frame position rather than shifted, so an
  // aborted partial frame needs no clearing: every position is rewritten
  // before the next frame can complete.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (wr_en) begin
      shift_reg[wr_index] <= bus.tdm_data;
    end
  end

  // frame_done arrives the cycle after the last bit was stored, so the
  // buffer is already complete here. A back-to-back sync in this same
  // cycle only modifies shift_reg after this copy has taken it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch_reg         <= '0;
      word_ready_reg <= 1'b0;
    end else begin
      word_ready_reg <= frame_done;
      if (frame_done) begin
        // Packed layout puts slot k at bits k*CH_WIDTH +: CH_WIDTH, which
        // matches the frame bit layout exactly.
        ch_reg <= shift_reg;
      end
    end
  end

  assign bus.word_ready = word_ready_reg;
  assign bus.ch0        = ch_reg[0];
  assign bus.ch1        = ch_reg[1];
  assign bus.ch2        = ch_reg[2];
  assign bus.ch3        = ch_reg[3];
  assign bus.ch4        = ch_reg[4];

endmodule

// File: tb/tb_tdm_deserializer.sv
// tb_tdm_deserializer
// Directed and randomized bench for tdm_deserializer. A reference model
// keeps the bits received since the last sync in a queue; 160 of them make
// a frame that appears on the outputs one clock later.
module tb_tdm_deserializer;
  import tdm_deserializer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  tdm_deserializer_if bus ();

  tdm_deserializer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  localparam logic [FRAME_BITS-1:0] FRAME_A =
    {32'h555555FA, 32'h555555FB, 32'h555555FC, 32'h555555FE, 32'h555555FF};
  localparam logic [FRAME_BITS-1:0] FRAME_SWAP =
    {32'h555555FF, 32'h555555FE, 32'h555555FC, 32'h555555FB, 32'h555555FA};

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int pulse_count = 0;
  int pulse_cycle[$];

  // Reference model state
  bit                    model_q[$];
  logic [FRAME_BITS-1:0] exp_out;
  logic [FRAME_BITS-1:0] pend_val;
  logic                  pend;
  logic                  exp_ready;

  function automatic logic [FRAME_BITS-1:0] obs_out();
    return {bus.ch4, bus.ch3, bus.ch2, bus.ch1, bus.ch0};
  endfunction

  function automatic logic [FRAME_BITS-1:0] rand_frame();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [FRAME_BITS-1:0] obs,
                       input logic [FRAME_BITS-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    pend      = 1'b0;
    pend_val  = '0;
    exp_out   = '0;
    exp_ready = 1'b0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check.
  task automatic step(input logic d, input logic s, input logic e);
    bus.tdm_data = d;
    bus.tdm_sync = s;
    bus.tdm_clk  = e;
    @(posedge clock);
    #1;
    cycle++;
    exp_ready = pend;
    if (pend) exp_out = pend_val;
    pend = 1'b0;
    if (e) begin
      if (s) begin
        model_q.delete();
        model_q.push_back(d);
      end else if (model_q.size() != 0) begin
        model_q.push_back(d);
      end
      if (model_q.size() == FRAME_BITS) begin
        for (int i = 0; i < FRAME_BITS; i++) pend_val[i] = model_q[i];
        pend = 1'b1;
        model_q.delete();
      end
    end
    check("word_ready", FRAME_BITS'(bus.word_ready), FRAME_BITS'(exp_ready));
    check("channels", obs_out(), exp_out);
    if (bus.word_ready === 1'b1) begin
      pulse_count++;
      pulse_cycle.push_back(cycle);
    end
  endtask

  task automatic send_frame(input logic [FRAME_BITS-1:0] f, input bit gated);
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (gated) step(1'($urandom()), 1'($urandom()), 1'b0);
      step(f[i], i == 0, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom()), 1'b0, 1'b0);
  endtask

  initial begin
    logic [FRAME_BITS-1:0] fr_b, fr_c, fr_d, fr_e, fr_f, fr_g;
    int pulses_before;
    int last_bit_cycle;

    bus.tdm_data = 1'b0;
    bus.tdm_sync = 1'b0;
    bus.tdm_clk  = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_ch", obs_out(), '0);
    check("reset_ready", FRAME_BITS'(bus.word_ready), '0);
    @(negedge clock);
    reset = 1'b0;

    // Frame test: known channel values, single pulse one clock after the last bit
    pulses_before = pulse_count;
    send_frame(FRAME_A, 1'b0);
    last_bit_cycle = cycle;
    idle(3);
    check("frame_ch0", FRAME_BITS'(bus.ch0), FRAME_BITS'(32'h555555FF));
    check("frame_ch1", FRAME_BITS'(bus.ch1), FRAME_BITS'(32'h555555FE));
    check("frame_ch2", FRAME_BITS'(bus.ch2), FRAME_BITS'(32'h555555FC));
    check("frame_ch3", FRAME_BITS'(bus.ch3), FRAME_BITS'(32'h555555FB));
    check("frame_ch4", FRAME_BITS'(bus.ch4), FRAME_BITS'(32'h555555FA));
    check("frame_pulses", FRAME_BITS'(pulse_count - pulses_before), FRAME_BITS'(1));
    check("frame_latency", FRAME_BITS'(pulse_cycle[pulse_cycle.size()-1] - last_bit_cycle),
          FRAME_BITS'(1));

    // Reset after bit 70 aborts the frame and clears the outputs at once
    fr_b = rand_frame();
    for (int i = 0; i < 70; i++) step(fr_b[i], i == 0, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check("midreset_ch", obs_out(), '0);
    check("midreset_ready", FRAME_BITS'(bus.word_ready), '0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 70; i < FRAME_BITS; i++) step(fr_b[i], 1'b0, 1'b1);
    fr_c = rand_frame();
    send_frame(fr_c, 1'b0);
    idle(2);
    check("after_reset_frame", obs_out(), fr_c);

    // Data without sync changes nothing
    pulses_before = pulse_count;
    for (int i = 0; i < 200; i++) step(1'($urandom()), 1'b0, 1'b1);
    check("nosync_pulses", FRAME_BITS'(pulse_count - pulses_before), '0);
    check("nosync_hold", obs_out(), fr_c);

    // Sync at bit 90 restarts; only the second frame lands
    pulses_before = pulse_count;
    fr_d = rand_frame();
    for (int i = 0; i < 90; i++) step(fr_d[i], i == 0, 1'b1);
    fr_e = rand_frame();
    send_frame(fr_e, 1'b0);
    idle(2);
    check("restart_pulses", FRAME_BITS'(pulse_count - pulses_before), FRAME_BITS'(1));
    check("restart_frame", obs_out(), fr_e);

    // 50% duty strobe with random data/sync on gated cycles
    pulses_before = pulse_count;
    send_frame(FRAME_A, 1'b1);
    idle(3);
    check("gated_frame", obs_out(), FRAME_A);
    check("gated_pulses", FRAME_BITS'(pulse_count - pulses_before), FRAME_BITS'(1));

    // Back-to-back frames, no idle bit between them
    pulses_before = pulse_count;
    send_frame(FRAME_SWAP, 1'b0);
    for (int i = 0; i < FRAME_BITS; i++) begin
      step(FRAME_A[i], i == 0, 1'b1);
      if (i == 100) check("b2b_hold", obs_out(), FRAME_SWAP);
    end
    idle(2);
    check("b2b_pulses", FRAME_BITS'(pulse_count - pulses_before), FRAME_BITS'(2));
    check("b2b_spacing", FRAME_BITS'(pulse_cycle[pulse_cycle.size()-1] -
          pulse_cycle[pulse_cycle.size()-2]), FRAME_BITS'(FRAME_BITS));
    check("b2b_final", obs_out(), FRAME_A);

    // Sync coinciding with bit 159 restarts without an update
    pulses_before = pulse_count;
    fr_f = rand_frame();
    fr_g = rand_frame();
    for (int i = 0; i < FRAME_BITS - 1; i++) step(fr_f[i], i == 0, 1'b1);
    send_frame(fr_g, 1'b0);
    idle(2);
    check("sync159_pulses", FRAME_BITS'(pulse_count - pulses_before), FRAME_BITS'(1));
    check("sync159_frame", obs_out(), fr_g);

    // Randomized soak against the model
    for (int i = 0; i < 4000; i++)
      step(1'($urandom()), $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
